// File: rtl/hp_display_counter.sv
// hp_display_counter: per-frame HP bookkeeping plus a seven-segment style
// numeric overlay for the VGA object mux. Hit/heal pulses accumulate during
// the frame, are applied once at startOfFrame, then the new HP is converted
// to BCD by a sequential double-dabble before it reaches the display.
module hp_display_counter #(
  parameter int          MAX_HP       = 100,
  parameter int          HIT_STEP     = 25,
  parameter int          HEAL_STEP    = 25,
  parameter int          LOW_THRESH   = 25,
  parameter int          BLINK_FRAMES = 16,
  parameter int          NUM_DIGITS   = 3,
  parameter int          DIGIT_W      = 16,
  parameter int          DIGIT_H      = 32,
  parameter logic [7:0]  DIGIT_COLOR  = 8'hFF
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [10:0] offsetX,
  input  logic [10:0] offsetY,
  input  logic        got_hit,
  input  logic        heal,
  input  logic        restart,
  input  logic        startOfFrame,
  output logic        drawingRequest,
  output logic [7:0]  RGBout,
  output logic [7:0]  hp_value,
  output logic        hp_zero,
  output logic        busy
);

  localparam int HP_W     = $clog2(MAX_HP + 1);
  localparam int BCD_W    = 4 * NUM_DIGITS;
  localparam int CNT_W    = (HP_W > 1) ? $clog2(HP_W) : 1;
  localparam int BL_W     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int DW_LOG   = $clog2(DIGIT_W);
  localparam int STEP_MAX = (HIT_STEP > HEAL_STEP) ? HIT_STEP : HEAL_STEP;
  localparam int CALC_RAW = HP_W + $clog2(STEP_MAX + 1) + 6;
  localparam int CALC_W   = (CALC_RAW > HP_W + 9) ? CALC_RAW : HP_W + 9;
  // glyph geometry: stroke thickness and vertical midline
  localparam int SEG_T    = DIGIT_W / 8;
  localparam int MID      = DIGIT_H / 2;

  // Elaboration-time binary to BCD for the reset/restart display value.
  function automatic logic [BCD_W-1:0] to_bcd(input int v);
    logic [BCD_W-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  localparam logic [BCD_W-1:0] MAX_BCD = to_bcd(MAX_HP);

  // Seven-segment glyph ROM: segment set per digit, rectangles per segment.
  function automatic logic glyph_px(input logic [3:0] dg, input int col, input int row);
    logic [6:0] seg;  // {a,b,c,d,e,f,g}
    logic hx, lc, rc, up, lo;
    case (dg)
      4'd0:    seg = 7'b1111110;
      4'd1:    seg = 7'b0110000;
      4'd2:    seg = 7'b1101101;
      4'd3:    seg = 7'b1111001;
      4'd4:    seg = 7'b0110011;
      4'd5:    seg = 7'b1011011;
      4'd6:    seg = 7'b1011111;
      4'd7:    seg = 7'b1110000;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1111011;
      default: seg = 7'b0000000;
    endcase
    hx = (col >= SEG_T) && (col < DIGIT_W - SEG_T);
    lc = (col >= SEG_T) && (col < 2 * SEG_T);
    rc = (col >= DIGIT_W - 2 * SEG_T) && (col < DIGIT_W - SEG_T);
    up = (row >= SEG_T) && (row < MID + SEG_T / 2);
    lo = (row >= MID - SEG_T / 2) && (row < DIGIT_H - SEG_T);
    return (seg[6] && hx && row >= SEG_T && row < 2 * SEG_T) ||
           (seg[5] && rc && up) ||
           (seg[4] && rc && lo) ||
           (seg[3] && hx && row >= DIGIT_H - 2 * SEG_T && row < DIGIT_H - SEG_T) ||
           (seg[2] && lc && lo) ||
           (seg[1] && lc && up) ||
           (seg[0] && hx && row >= MID - SEG_T / 2 && row < MID + SEG_T / 2);
  endfunction

  typedef enum logic [1:0] {IDLE, APPLY, CONVERT} state_t;

  state_t            state_q, state_d;
  logic [HP_W-1:0]   hp;
  logic [HP_W-1:0]   hp_new;
  logic [3:0]        pend_hit, pend_heal;
  logic              ev_hit, ev_heal;
  logic [HP_W-1:0]   work_bin;
  logic [BCD_W-1:0]  work_bcd, adj_bcd, dd_next, disp_bcd;
  logic [CNT_W-1:0]  conv_cnt;
  logic              conv_last;
  logic [BL_W-1:0]   blink_cnt;
  logic              blink_on;
  logic              hp_low;

  logic signed [CALC_W-1:0] hp_s, hit_s, heal_s, sum_s;

  logic [10:0]       dig_idx;
  int                col, row;
  logic              in_box;
  logic [3:0]        cur_digit;
  logic              cur_blank;
  logic              lead;
  logic [3:0]        dv;

  // A simultaneous hit and heal cancel out.
  assign ev_hit  = got_hit & ~heal;
  assign ev_heal = heal & ~got_hit;

  assign conv_last = (conv_cnt == CNT_W'(HP_W - 1));
  assign hp_low    = (hp != '0) && (int'(hp) <= LOW_THRESH);

  assign busy     = (state_q != IDLE);
  assign hp_zero  = (hp == '0);
  assign hp_value = 8'(hp);
  assign RGBout   = DIGIT_COLOR;

  // State register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state: one APPLY cycle, HP_W CONVERT cycles; restart wins.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (startOfFrame) state_d = APPLY;
      APPLY:   state_d = CONVERT;
      CONVERT: if (conv_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (restart) state_d = IDLE;
  end

  // Signed frame update, clamped to [0, MAX_HP]; a dead player stays dead.
  always_comb begin
    hp_s   = signed'(CALC_W'(hp));
    hit_s  = signed'(CALC_W'(pend_hit)) * signed'(CALC_W'(HIT_STEP));
    heal_s = signed'(CALC_W'(pend_heal)) * signed'(CALC_W'(HEAL_STEP));
    sum_s  = hp_s - hit_s + heal_s;
    if (hp == '0)
      hp_new = '0;
    else if (sum_s < 0)
      hp_new = '0;
    else if (sum_s > signed'(CALC_W'(MAX_HP)))
      hp_new = HP_W'(MAX_HP);
    else
      hp_new = sum_s[HP_W-1:0];
  end

  // Pending event counters, saturating; reloaded from this cycle's event in APPLY.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pend_hit  <= '0;
      pend_heal <= '0;
    end else if (restart) begin
      pend_hit  <= '0;
      pend_heal <= '0;
    end else if (state_q == APPLY) begin
      pend_hit  <= 4'(ev_hit);
      pend_heal <= 4'(ev_heal);
    end else begin
      if (ev_hit && pend_hit != 4'hF)   pend_hit  <= pend_hit + 4'd1;
      if (ev_heal && pend_heal != 4'hF) pend_heal <= pend_heal + 4'd1;
    end
  end

  // Double-dabble step: add 3 to any digit >= 5, then shift in the next bit.
  always_comb begin
    adj_bcd = work_bcd;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (work_bcd[i*4 +: 4] >= 4'd5) adj_bcd[i*4 +: 4] = work_bcd[i*4 +: 4] + 4'd3;
    dd_next = {adj_bcd[BCD_W-2:0], work_bin[HP_W-1]};
  end

  // HP register and conversion datapath; display digits change only on the last step.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hp       <= HP_W'(MAX_HP);
      disp_bcd <= MAX_BCD;
      work_bcd <= '0;
      work_bin <= '0;
      conv_cnt <= '0;
    end else if (restart) begin
      hp       <= HP_W'(MAX_HP);
      disp_bcd <= MAX_BCD;
      conv_cnt <= '0;
    end else begin
      case (state_q)
        APPLY: begin
          hp       <= hp_new;
          work_bin <= hp_new;
          work_bcd <= '0;
          conv_cnt <= '0;
        end
        CONVERT: begin
          work_bin <= work_bin << 1;
          work_bcd <= dd_next;
          conv_cnt <= conv_cnt + CNT_W'(1);
          if (conv_last) disp_bcd <= dd_next;
        end
        default: ;
      endcase
    end
  end

  // Low-HP blink: frame counter with a phase toggle every BLINK_FRAMES frames.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (restart || !hp_low) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (startOfFrame) begin
      if (blink_cnt == BL_W'(BLINK_FRAMES - 1)) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + BL_W'(1);
      end
    end
  end

  // Pick the digit under the beam and decide whether it is a blanked leading zero.
  always_comb begin
    dig_idx   = offsetX >> DW_LOG;
    col       = int'(offsetX[DW_LOG-1:0]);
    row       = int'(offsetY);
    in_box    = (int'(offsetX) < NUM_DIGITS * DIGIT_W) && (row < DIGIT_H);
    cur_digit = '0;
    cur_blank = 1'b1;
    lead      = 1'b1;
    dv        = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      dv = disp_bcd[i*4 +: 4];
      if (int'(dig_idx) == NUM_DIGITS - 1 - i) begin
        cur_digit = dv;
        cur_blank = lead && (dv == 4'd0) && (i != 0);
      end
      if (dv != 4'd0) lead = 1'b0;
    end
  end

  // Registered pixel request, one clock after the offsets.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) drawingRequest <= 1'b0;
    else         drawingRequest <= in_box && !cur_blank && blink_on &&
                                   glyph_px(cur_digit, col, row);
  end

endmodule

// File: tb/tb_hp_display_counter.sv
// Bench for hp_display_counter: frame-level behavioural model checked every
// cycle, directed scenarios with hand-computed pixel/HP values, then random.
module tb_hp_display_counter;

  logic        clk = 1'b0;
  logic        resetN;
  logic [10:0] offsetX, offsetY;
  logic        got_hit, heal, restart, startOfFrame;
  logic        drawingRequest;
  logic [7:0]  RGBout, hp_value;
  logic        hp_zero, busy;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  // model state
  int m_hp, m_ph, m_pl, m_rem, m_disp, m_bcnt, m_v, m_eh, m_el;
  bit m_on, m_dr;

  hp_display_counter dut (
    .clk(clk), .resetN(resetN), .offsetX(offsetX), .offsetY(offsetY),
    .got_hit(got_hit), .heal(heal), .restart(restart), .startOfFrame(startOfFrame),
    .drawingRequest(drawingRequest), .RGBout(RGBout), .hp_value(hp_value),
    .hp_zero(hp_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Which digits light each segment: bit i set => digit i uses it.
  function automatic bit seg_lit(input int dg, input int col, input int row);
    bit [9:0] sa, sb, sc, sd, se, sf, sg;
    bit hx, lc, rc, up, lo;
    sa = 10'b1111101101; sb = 10'b1110011111; sc = 10'b1111111011;
    sd = 10'b1101101101; se = 10'b0101000101; sf = 10'b1101110001;
    sg = 10'b1101111100;
    hx = col >= 2 && col <= 13;
    lc = col == 2 || col == 3;
    rc = col == 12 || col == 13;
    up = row >= 2 && row <= 16;
    lo = row >= 15 && row <= 29;
    return (sa[dg] && hx && (row == 2 || row == 3)) ||
           (sg[dg] && hx && (row == 15 || row == 16)) ||
           (sd[dg] && hx && (row == 28 || row == 29)) ||
           (sb[dg] && rc && up) || (sc[dg] && rc && lo) ||
           (sf[dg] && lc && up) || (se[dg] && lc && lo);
  endfunction

  // Pixel of the 3-digit decimal rendering of val; leading zeros blank.
  function automatic bit model_pixel(input int x, input int y, input int val, input bit on);
    int d, p;
    if (x >= 48 || y >= 32 || !on) return 0;
    d = x / 16;
    p = (d == 0) ? 100 : (d == 1) ? 10 : 1;
    if (d < 2 && val < p) return 0;
    return seg_lit((val / p) % 10, x % 16, y);
  endfunction

  // Behavioural model: HP per frame, display latency, blink frame count.
  initial forever begin
    @(posedge clk or negedge resetN);
    if (!resetN) begin
      m_hp = 100; m_ph = 0; m_pl = 0; m_rem = 0; m_disp = 100;
      m_bcnt = 0; m_on = 1; m_dr = 0;
    end else begin
      m_dr = model_pixel(int'(offsetX), int'(offsetY), m_disp, m_on);
      if (restart) begin
        m_hp = 100; m_ph = 0; m_pl = 0; m_rem = 0; m_disp = 100; m_bcnt = 0; m_on = 1;
      end else begin
        if (m_hp > 0 && m_hp <= 25) begin
          if (startOfFrame) begin
            m_bcnt++;
            if (m_bcnt == 16) begin m_bcnt = 0; m_on = !m_on; end
          end
        end else begin
          m_bcnt = 0; m_on = 1;
        end
        m_eh = (got_hit && !heal) ? 1 : 0;
        m_el = (heal && !got_hit) ? 1 : 0;
        if (m_rem == 8) begin
          if (m_hp != 0) begin
            m_v = m_hp - 25 * m_ph + 25 * m_pl;
            m_hp = (m_v < 0) ? 0 : (m_v > 100) ? 100 : m_v;
          end
          m_ph = m_eh; m_pl = m_el;
        end else begin
          m_ph = (m_ph + m_eh > 15) ? 15 : m_ph + m_eh;
          m_pl = (m_pl + m_el > 15) ? 15 : m_pl + m_el;
        end
        if (m_rem == 1) m_disp = m_hp;
        if (m_rem > 0) m_rem--;
        else if (startOfFrame) m_rem = 8;
      end
    end
  end

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("hp_value", int'(hp_value), m_hp);
      chk("busy", int'(busy), (m_rem > 0) ? 1 : 0);
      chk("hp_zero", int'(hp_zero), (m_hp == 0) ? 1 : 0);
      chk("drawingRequest", int'(drawingRequest), int'(m_dr));
      chk("RGBout", int'(RGBout), 255);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    got_hit = 0; heal = 0; startOfFrame = 0; restart = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin step(); n++; end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic frame();
    startOfFrame = 1;
    step();
    wait_idle();
  endtask

  task automatic probe(input string name, input int x, input int y, input int exp);
    offsetX = 11'(x); offsetY = 11'(y);
    step();
    chk(name, int'(drawingRequest), exp);
  endtask

  task automatic hits(input int n);
    for (int i = 0; i < n; i++) begin got_hit = 1; step(); end
  endtask

  initial begin
    int n, offs;
    resetN = 0; offsetX = 0; offsetY = 0;
    got_hit = 0; heal = 0; restart = 0; startOfFrame = 0;
    repeat (3) @(posedge clk);
    #1 resetN = 1;
    chk_en = 1;

    // T1 reset shows "100"
    chk("rst_hp", int'(hp_value), 100);
    chk("rst_busy", int'(busy), 0);
    chk("rst_zero", int'(hp_zero), 0);
    probe("rst_px_1", 12, 5, 1);
    probe("rst_px_0f", 18, 5, 1);
    probe("rst_px_0mid", 24, 16, 0);
    probe("rst_px_out", 50, 5, 0);
    for (int y = 0; y < 32; y += 7)
      for (int x = 0; x < 48; x += 3) begin offsetX = 11'(x); offsetY = 11'(y); step(); end

    // T2 one hit -> 75, busy 1+7
    hits(1);
    startOfFrame = 1;
    step();
    n = 0;
    while (busy && n < 40) begin n++; step(); end
    chk("busy_len", n, 8);
    chk("hit_hp", int'(hp_value), 75);
    probe("hit_blank_msd", 12, 5, 0);
    probe("hit_px_7", 21, 2, 1);
    probe("hit_px_5", 34, 5, 1);

    // T4 simultaneous hit+heal, then heal clamp
    got_hit = 1; heal = 1; step();
    frame();
    chk("simul_hp", int'(hp_value), 75);
    for (int i = 0; i < 3; i++) begin heal = 1; step(); end
    frame();
    chk("heal_clamp", int'(hp_value), 100);

    // T3 20 hits saturate, clamp to 0, dead stays dead
    hits(20);
    frame();
    chk("dead_hp", int'(hp_value), 0);
    chk("dead_zero", int'(hp_zero), 1);
    probe("dead_px_lsd", 34, 5, 1);
    probe("dead_px_msd", 2, 5, 0);
    probe("dead_px_mid", 18, 5, 0);
    heal = 1; step();
    frame();
    chk("dead_heal", int'(hp_value), 0);

    restart = 1; step();
    chk("restart_hp", int'(hp_value), 100);
    chk("restart_zero", int'(hp_zero), 0);

    // T5 blink at hp=25
    hits(3);
    frame();
    chk("low_hp", int'(hp_value), 25);
    offs = 0;
    for (int k = 1; k <= 32; k++) begin
      frame();
      probe("blink_px", 21, 2, (k >= 16 && k < 32) ? 0 : 1);
    end
    restart = 1; step();
    hits(2);
    frame();
    chk("mid_hp", int'(hp_value), 50);
    for (int k = 0; k < 40; k++) begin
      frame();
      offsetX = 11'd21; offsetY = 11'd2;
      step();
      if (!drawingRequest) offs++;
    end
    chk("no_blink_50", offs, 0);

    // T6 restart and reset during CONVERT
    hits(1);
    startOfFrame = 1; step();
    step(); step(); step();
    chk("conv_busy", int'(busy), 1);
    restart = 1; step();
    chk("rs_conv_busy", int'(busy), 0);
    chk("rs_conv_hp", int'(hp_value), 100);
    probe("rs_conv_px", 12, 5, 1);
    hits(1);
    startOfFrame = 1; step();
    step(); step(); step();
    resetN = 0;
    #1;
    chk("arst_hp", int'(hp_value), 100);
    chk("arst_busy", int'(busy), 0);
    chk("arst_dr", int'(drawingRequest), 0);
    step();
    resetN = 1;
    step();

    // randomized traffic against the model
    for (int c = 0; c < 6000; c++) begin
      got_hit = ($urandom_range(0, 7) == 0);
      heal = ((c / 750) % 2 == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 31) == 0);
      restart = ($urandom_range(0, 599) == 0);
      startOfFrame = ($urandom_range(0, 14) == 0);
      offsetX = 11'($urandom_range(0, 55));
      offsetY = 11'($urandom_range(0, 39));
      step();
    end

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
